// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// rtl/nibble_serial_adder_ctrl_pkg.sv - shared types and constants for the nibble-serial adder
// Contents: state_t (IDLE/RUN/DONE) sequencer states, NIBBLE_W slice width.
package nibble_serial_adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_add4_slice.sv
// rtl/nibble_serial_adder_ctrl_add4_slice.sv - combinational 4-bit ripple full-adder slice
// Ports: x, y (4-bit addends), ci (carry in), s (4-bit sum), co (carry out).
module add4_slice (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        co = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// rtl/nibble_serial_adder_ctrl.sv - WIDTH-bit add/sub sequenced through one 4-bit slice, LSB nibble first
// Ports: clk, rst_n (async active-low); start_valid/start_ready with a, b, cin, sub;
//        res_valid/res_ready with sum, cout, overflow; busy while RUN or DONE.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               cout_reg;
    logic               ovf_reg;

    logic [NIBBLE_W-1:0] x_nib;
    logic [NIBBLE_W-1:0] y_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                co_nib;

    // Nibble mux feeding the single shared slice.
    assign x_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign y_nib = b_reg[idx*NIBBLE_W +: NIBBLE_W];

    add4_slice u_slice (
        .x  (x_nib),
        .y  (y_nib),
        .ci (carry),
        .s  (s_nib),
        .co (co_nib)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        // Subtraction runs as A + ~B + ~borrow, so the slice only ever adds.
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[idx*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= co_nib;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_reg <= co_nib;
                        // b_reg already holds ~B for subtraction, so one rule covers both.
                        ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                    (s_nib[NIBBLE_W-1] != a_reg[WIDTH-1]);
                        idx      <= '0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign sum         = sum_reg;
    assign cout        = cout_reg;
    assign overflow    = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb/tb_nibble_serial_adder_ctrl.sv - scoreboard bench for nibble_serial_adder_ctrl (WIDTH=16)
module tb_nibble_serial_adder_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc;

    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sum         (sum),
        .cout        (cout),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operands, returns {overflow, cout, sum}.
    function automatic logic [17:0] ref_op(input logic [15:0] xa, input logic [15:0] xb,
                                           input logic xc, input logic xs);
        int ua = xa;
        int ub = xb;
        int sa = $signed(xa);
        int sb = $signed(xb);
        int ci = xc;
        int ur, sr;
        logic co, ov;
        logic [15:0] s;
        if (!xs) begin
            ur = ua + ub + ci;
            sr = sa + sb + ci;
            co = (ur > 65535);
        end else begin
            ur = ua - ub - ci;
            sr = sa - sb - ci;
            co = (ur >= 0);
        end
        s  = ur[15:0];
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, s};
    endfunction

    // Monitor: every completed result handshake is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum=%0h with no pending operation, required none", sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sum", 32'(sum), 32'(mon_e[15:0]));
                chk("cout", 32'(cout), 32'(mon_e[16]));
                chk("overflow", 32'(overflow), 32'(mon_e[17]));
            end
        end
    end

    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs, input bit push);
        bit ok = 0;
        a = xa; b = xb; cin = xc; sub = xs;
        start_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_ready) begin
                ok = 1;
                acc_cyc = cyc + 1;
                if (push) exp_q.push_back(ref_op(xa, xb, xc, xs));
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got start_ready=0 for 200 cycles, required 1");
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid) break;
        end
    endtask

    initial begin
        logic [17:0] held;
        int n, prev, guard;

        rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 32'(sum), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_start_ready", 32'(start_ready), 32'h1);
        @(posedge clk);
        #1;

        // Directed arithmetic, with latency measured on the first op.
        start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1);
        wait_res();
        chk("latency", 32'(cyc - acc_cyc), 32'd4);
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1);
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
        start_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1);
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1);

        // Backpressure in DONE while inputs and start_valid wiggle.
        wait_res();
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        start_op(16'hABCD, 16'h1111, 1'b1, 1'b0, 1);
        wait_res();
        held = {overflow, cout, sum};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a = 16'($urandom); b = 16'($urandom);
            start_valid = ~start_valid;
            @(negedge clk);
            chk("bp_hold", 32'({overflow, cout, sum}), 32'(held));
            chk("bp_start_ready", 32'(start_ready), 32'h0);
            chk("bp_res_valid", 32'(res_valid), 32'h1);
        end
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(res_valid), 32'h0);
        chk("bp_release_ready", 32'(start_ready), 32'h1);

        // Reset in the middle of RUN aborts the operation.
        start_op(16'h4321, 16'h1234, 1'b0, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 32'(sum), 32'h0);
        chk("abort_res_valid", 32'(res_valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_start_ready", 32'(start_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_result", 32'(res_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1);

        // Back-to-back random stream with start_valid held high.
        wait_res();
        @(posedge clk);
        #1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        start_valid = 1'b1;
        n = 0; prev = -1; guard = 0;
        while (n < 1000 && guard < 10000) begin
            @(negedge clk);
            guard++;
            if (start_ready) begin
                exp_q.push_back(ref_op(a, b, cin, sub));
                if (prev >= 0) chk("b2b_spacing", 32'(cyc + 1 - prev), 32'd6);
                prev = cyc + 1;
                n++;
                @(posedge clk);
                #1;
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            end
        end
        chk("b2b_count", 32'(n), 32'd1000);
        start_valid = 1'b0;

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
